// File: rtl/kernel_weight_buffer_pkg.sv
// Shared types for the conv weight buffer: defaults, FSM states, slice index.
// Imported by the bank, the top and the interface users.
package cnn_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int KMAX_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic int unsigned slice_idx(
    input int unsigned r,
    input int unsigned c,
    input int unsigned kmax,
    input int unsigned dw
  );
    return (r * kmax + c) * dw;
  endfunction

endpackage

// File: rtl/kernel_weight_buffer_if.sv
// Weight stream handshake: master drives w_valid/w_din, slave drives w_ready.
// One beat transfers when w_valid && w_ready at a rising clk edge.
interface kernel_weight_buffer_if #(
  parameter int DWIDTH = 16
);
  logic              w_valid;
  logic              w_ready;
  logic [DWIDTH-1:0] w_din;

  modport master (output w_valid, output w_din, input w_ready);
  modport slave  (input w_valid, input w_din, output w_ready);
endinterface

// File: rtl/kernel_weight_buffer_bank.sv
// KMAXxKMAX register array: clear, indexed write, whole-bank copy-in.
// Ports: clk, rst, clr, we, wr_row/wr_col/wr_data, ld/ld_data, q (flat bus).
module weight_bank
  import cnn_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int KMAX   = KMAX_DEF,
  parameter int CNT_W  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          we,
  input  logic [CNT_W-1:0]              wr_row,
  input  logic [CNT_W-1:0]              wr_col,
  input  logic [DWIDTH-1:0]             wr_data,
  input  logic                          ld,
  input  logic [DWIDTH*KMAX*KMAX-1:0]   ld_data,
  output logic [DWIDTH*KMAX*KMAX-1:0]   q
);

  // Clear and write may coincide: the write to one element wins over
  // the clear of that element, everything else goes to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_data;
    end else begin
      if (clr)
        q <= '0;
      for (int r = 0; r < KMAX; r++) begin
        for (int c = 0; c < KMAX; c++) begin
          if (we && wr_row == CNT_W'(r) && wr_col == CNT_W'(c))
            q[slice_idx(r, c, KMAX, DWIDTH) +: DWIDTH] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/kernel_weight_buffer.sv
// Double-buffered KxK conv weight store: stream into shadow, swap to active.
// Ports: clk, rst, w (stream), cfg_ksize, swap_req, abort, kernel + status.
module kernel_weight_buffer
  import cnn_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int KMAX   = KMAX_DEF,
  parameter int CNT_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  kernel_weight_buffer_if.slave       w,
  input  logic [2:0]                  cfg_ksize,
  input  logic                        swap_req,
  input  logic                        abort,
  output logic [DWIDTH*KMAX*KMAX-1:0] kernel,
  output logic                        kernel_valid,
  output logic [2:0]                  active_ksize,
  output logic                        shadow_full,
  output logic                        swap_err,
  output logic                        cfg_err
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   row, row_nx;
  logic [CNT_W-1:0]   col, col_nx;
  logic [2:0]         ksz, ksz_nx;
  logic [CNT_W-1:0]   km1;
  logic [2:0]         k_eff;
  logic               cfg_bad;
  logic               w_rdy;
  logic               beat;
  logic               bank_clr;
  logic               swap;
  logic               swap_err_nx;
  logic               cfg_err_nx;
  logic [DWIDTH*KMAX*KMAX-1:0] shadow_q;

  assign cfg_bad = (cfg_ksize == 3'd0) || (cfg_ksize > 3'(KMAX));
  // First beat of a load uses the incoming size, later beats the latched one.
  assign k_eff = (state == IDLE) ? cfg_ksize : ksz;
  assign km1 = CNT_W'(k_eff) - CNT_W'(1);

  always_comb begin
    state_nx    = state;
    row_nx      = row;
    col_nx      = col;
    ksz_nx      = ksz;
    w_rdy       = (state != FULL);
    beat        = 1'b0;
    bank_clr    = 1'b0;
    swap        = 1'b0;
    swap_err_nx = 1'b0;
    cfg_err_nx  = 1'b0;
    if (abort) begin
      w_rdy = 1'b0;
      if (state == LOAD) begin
        state_nx = IDLE;
        row_nx   = '0;
        col_nx   = '0;
      end
    end else begin
      if (swap_req) begin
        if (state == FULL) begin
          swap     = 1'b1;
          state_nx = IDLE;
        end else begin
          swap_err_nx = 1'b1;
        end
      end
      if (state == IDLE && w.w_valid && cfg_bad) begin
        w_rdy      = 1'b0;
        cfg_err_nx = 1'b1;
      end
      beat = w.w_valid && w_rdy;
      if (beat) begin
        if (state == IDLE) begin
          ksz_nx   = cfg_ksize;
          bank_clr = 1'b1;
        end
        if (col == km1 && row == km1) begin
          state_nx = FULL;
          row_nx   = '0;
          col_nx   = '0;
        end else begin
          state_nx = LOAD;
          if (col == km1) begin
            col_nx = '0;
            row_nx = row + CNT_W'(1);
          end else begin
            col_nx = col + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      ksz          <= '0;
      active_ksize <= '0;
      kernel_valid <= 1'b0;
      swap_err     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      col      <= col_nx;
      ksz      <= ksz_nx;
      swap_err <= swap_err_nx;
      cfg_err  <= cfg_err_nx;
      if (swap) begin
        active_ksize <= ksz;
        kernel_valid <= 1'b1;
      end
    end
  end

  assign w.w_ready   = w_rdy;
  assign shadow_full = (state == FULL);

  weight_bank #(
    .DWIDTH (DWIDTH),
    .KMAX   (KMAX),
    .CNT_W  (CNT_W)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .clr     (bank_clr),
    .we      (beat),
    .wr_row  (row),
    .wr_col  (col),
    .wr_data (w.w_din),
    .ld      (1'b0),
    .ld_data ('0),
    .q       (shadow_q)
  );

  weight_bank #(
    .DWIDTH (DWIDTH),
    .KMAX   (KMAX),
    .CNT_W  (CNT_W)
  ) u_active (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .we      (1'b0),
    .wr_row  ('0),
    .wr_col  ('0),
    .wr_data ('0),
    .ld      (swap),
    .ld_data (shadow_q),
    .q       (kernel)
  );

endmodule
